// File: rtl/vga_port_arbiter_pkg.sv
// Shared VGA pixel-port widths, requester indices and arbiter FSM encodings.
package vga_port_arbiter_pkg;

  localparam int X_W     = 9;
  localparam int Y_W     = 8;
  localparam int COLOR_W = 3;
  localparam int IDX_W   = 3;

  localparam int REQ_MAP    = 0;
  localparam int REQ_SPRITE = 1;
  localparam int REQ_ANIM   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_port_arbiter_rr_pick.sv
// Combinational round-robin finder: first set req bit scanning upward from ptr+1.
module vga_port_arbiter_rr_pick
  import vga_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset NUM_REQ wraps back to ptr itself, so the last grantee is checked last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vga_port_arbiter.sv
// Burst-granting round-robin arbiter for the shared VGA pixel-write port.
module vga_port_arbiter
  import vga_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  input  logic [NUM_REQ-1:0]         plot_in,
  input  logic [NUM_REQ*X_W-1:0]     x_in,
  input  logic [NUM_REQ*Y_W-1:0]     y_in,
  input  logic [NUM_REQ*COLOR_W-1:0] color_in,
  output logic                       plot_out,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic [COLOR_W-1:0]         color_out,
  output logic [IDX_W-1:0]           owner,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 drop_count,
  output arb_state_e                 fsm_state
);

  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  arb_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_found;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                wd_expired;
  logic [NUM_REQ-1:0]  drop_mask;

  vga_port_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign wd_expired = (MAX_HOLD > 0) && (hold_cnt == HOLD_W'(MAX_HOLD));
  assign fsm_state  = state;

  // Arbitration also runs on the RELEASE exit edge so a handover costs exactly
  // one grant-free cycle; RELEASE itself never grants the cycle it is entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      hold_cnt    <= '0;
      grant       <= '0;
      owner       <= '0;
      busy        <= 1'b0;
      plot_out    <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      color_out   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RELEASE: begin
          plot_out <= 1'b0;
          if (pick_found) begin
            grant    <= pick_onehot;
            owner    <= pick_idx;
            ptr      <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= HOLD_W'(1);
            state    <= ST_OWNED;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_OWNED: begin
          if (!req[owner]) begin
            grant    <= '0;
            busy     <= 1'b0;
            plot_out <= 1'b0;
            state    <= ST_RELEASE;
          end else if (wd_expired) begin
            grant       <= '0;
            busy        <= 1'b0;
            plot_out    <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_RELEASE;
          end else begin
            plot_out  <= plot_in[owner];
            x_out     <= x_in[owner*X_W +: X_W];
            y_out     <= y_in[owner*Y_W +: Y_W];
            color_out <= color_in[owner*COLOR_W +: COLOR_W];
            hold_cnt  <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          grant    <= '0;
          busy     <= 1'b0;
          plot_out <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Outside OWNED nobody owns the port, so every strobe is a dropped pixel.
  assign drop_mask = (state == ST_OWNED) ? (plot_in & ~grant) : plot_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (|drop_mask && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_port_arbiter.sv
// Directed bench for vga_port_arbiter: main instance plus a MAX_HOLD=16 watchdog instance.
module tb_vga_port_arbiter;
  import vga_port_arbiter_pkg::*;

  localparam int N = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   plot_in = '0;
  logic [N*9-1:0] x_in = '0;
  logic [N*8-1:0] y_in = '0;
  logic [N*3-1:0] color_in = '0;
  logic [N-1:0]   grant;
  logic           plot_out;
  logic [8:0]     x_out;
  logic [7:0]     y_out;
  logic [2:0]     color_out;
  logic [2:0]     owner;
  logic           busy;
  logic           timeout_err;
  logic [7:0]     drop_count;
  arb_state_e     fsm_state;

  logic [N-1:0]   w_req = '0;
  logic [N-1:0]   w_grant;
  logic           w_plot_out;
  logic [8:0]     w_x_out;
  logic [7:0]     w_y_out;
  logic [2:0]     w_color_out;
  logic [2:0]     w_owner;
  logic           w_busy;
  logic           w_timeout_err;
  logic [7:0]     w_drop_count;
  arb_state_e     w_fsm_state;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  vga_port_arbiter #(.NUM_REQ(N), .MAX_HOLD(0)) u_dut (
    .clock(clock), .reset(reset), .req(req), .grant(grant),
    .plot_in(plot_in), .x_in(x_in), .y_in(y_in), .color_in(color_in),
    .plot_out(plot_out), .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .owner(owner), .busy(busy), .timeout_err(timeout_err),
    .drop_count(drop_count), .fsm_state(fsm_state)
  );

  vga_port_arbiter #(.NUM_REQ(N), .MAX_HOLD(16)) u_wd (
    .clock(clock), .reset(reset), .req(w_req), .grant(w_grant),
    .plot_in(3'b000), .x_in(27'd0), .y_in(24'd0), .color_in(9'd0),
    .plot_out(w_plot_out), .x_out(w_x_out), .y_out(w_y_out), .color_out(w_color_out),
    .owner(w_owner), .busy(w_busy), .timeout_err(w_timeout_err),
    .drop_count(w_drop_count), .fsm_state(w_fsm_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot_out, 0);
    chk("rst_x", x_out, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_state", fsm_state, ST_IDLE);
    reset = 1'b0;

    // Single requester: grant one cycle after req, plot one cycle after plot_in
    req = 3'b001;
    tick();
    chk("single_grant", grant, 3'b001);
    chk("single_busy", busy, 1);
    chk("single_owner", owner, 0);
    chk("single_state", fsm_state, ST_OWNED);
    plot_in = 3'b001;
    x_in[8:0] = 9'd319; y_in[7:0] = 8'd239; color_in[2:0] = 3'd7;
    tick();
    chk("single_plot", plot_out, 1);
    chk("single_x", x_out, 319);
    chk("single_y", y_out, 239);
    chk("single_color", color_out, 7);
    plot_in = 3'b000;
    tick();
    chk("single_plot_low", plot_out, 0);
    chk("single_x_hold", x_out, 319);
    req = 3'b000;
    tick();
    chk("single_rel_grant", grant, 0);
    chk("single_rel_busy", busy, 0);
    chk("single_rel_state", fsm_state, ST_RELEASE);
    tick();
    chk("single_idle_state", fsm_state, ST_IDLE);
    chk("single_drop_none", drop_count, 0);

    // Simultaneous requests after reset: order 0,1,2, one dead cycle per handover
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 3'b111;
    tick();
    chk("sim_g0", grant, 3'b001);
    tick(); tick(); tick();
    chk("sim_g0_held", grant, 3'b001);
    req = 3'b110;
    tick();
    chk("sim_dead0_grant", grant, 0);
    chk("sim_dead0_plot", plot_out, 0);
    tick();
    chk("sim_g1", grant, 3'b010);
    chk("sim_owner1", owner, 1);
    tick(); tick(); tick();
    req = 3'b100;
    tick();
    chk("sim_dead1_grant", grant, 0);
    chk("sim_dead1_plot", plot_out, 0);
    tick();
    chk("sim_g2", grant, 3'b100);
    chk("sim_owner2", owner, 2);
    tick(); tick(); tick();
    req = 3'b000;
    tick();
    chk("sim_dead2_grant", grant, 0);
    tick();
    chk("sim_idle_grant", grant, 0);

    // Fairness: requesters 0 and 1 alternate, burst ends by a one-cycle req gap
    req = 3'b011;
    tick();
    chk("fair_a0", grant, 3'b001);
    req = 3'b010;
    tick();
    chk("fair_gap1", grant, 0);
    req = 3'b011;
    tick();
    chk("fair_a1", grant, 3'b010);
    req = 3'b001;
    tick();
    chk("fair_gap2", grant, 0);
    req = 3'b011;
    tick();
    chk("fair_a2", grant, 3'b001);
    req = 3'b010;
    tick();
    req = 3'b011;
    tick();
    chk("fair_a3", grant, 3'b010);
    req = 3'b000;
    tick(); tick();

    // Drops: owner 0 plots while requester 1 strobes 300 cycles
    req = 3'b001;
    tick();
    chk("drop_grant", grant, 3'b001);
    x_in[8:0] = 9'd5;  y_in[7:0] = 8'd6;  color_in[2:0] = 3'd2;
    x_in[17:9] = 9'd100; y_in[15:8] = 8'd101; color_in[5:3] = 3'd5;
    plot_in = 3'b011;
    tick();
    chk("drop_first", drop_count, 1);
    for (int i = 1; i < 300; i++) tick();
    chk("drop_sat", drop_count, 255);
    chk("drop_plot", plot_out, 1);
    chk("drop_x_owner", x_out, 5);
    chk("drop_color_owner", color_out, 2);
    plot_in = 3'b000;

    // Reset mid-burst with owner 1 plotting
    req = 3'b000;
    tick();
    req = 3'b010;
    tick();
    chk("mid_owner1", owner, 1);
    plot_in = 3'b010;
    tick();
    chk("mid_plot", plot_out, 1);
    chk("mid_x", x_out, 100);
    reset = 1'b1;
    req = 3'b011;
    plot_in = 3'b000;
    tick();
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_plot", plot_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_x", x_out, 0);
    reset = 1'b0;
    tick();
    chk("mid_after_grant", grant, 3'b001);

    // Strobe seen while idle counts as a drop
    req = 3'b000;
    tick(); tick();
    chk("idle_state", fsm_state, ST_IDLE);
    plot_in = 3'b100;
    tick();
    chk("idle_drop", drop_count, 1);
    chk("idle_plot", plot_out, 0);
    plot_in = 3'b000;

    // Watchdog: grant revoked after 16 cycles, re-granted after RELEASE
    w_req = 3'b100;
    tick();
    chk("wd_grant", w_grant, 3'b100);
    for (int i = 1; i < 16; i++) tick();
    chk("wd_held16", w_grant, 3'b100);
    chk("wd_no_err_yet", w_timeout_err, 0);
    tick();
    chk("wd_revoked", w_grant, 0);
    chk("wd_err", w_timeout_err, 1);
    chk("wd_busy", w_busy, 0);
    tick();
    chk("wd_regrant", w_grant, 3'b100);
    chk("wd_err_sticky", w_timeout_err, 1);
    chk("main_no_timeout", timeout_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_port_arbiter.md
Name: vga_port_arbiter

Overview:
- Shares the single VGA pixel-write port (X 9b, Y 8b, color 3b, plot strobe) among several drawing engines: map redraw, character sprite drawer and bridge/pillar animator.
- Grants whole bursts: a requester keeps the port for as long as it holds its request, so a full-screen redraw is never interleaved with sprite pixels.
- Sits between the drawing engines and the VGA adapter in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = map redraw.
- MAX_HOLD, 0, grant watchdog in cycles; 0 disables it. Otherwise a grant held MAX_HOLD cycles is revoked.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester burst request, level
- grant  out  NUM_REQ  one-hot grant, registered
- plot_in  in  NUM_REQ  per-requester pixel write strobe
- x_in  in  NUM_REQ*9  packed X; requester i occupies bits [9i+8:9i]
- y_in  in  NUM_REQ*8  packed Y
- color_in  in  NUM_REQ*3  packed color
- plot_out  out  1  write strobe to VGA adapter
- x_out  out  9  pixel X to VGA adapter
- y_out  out  8  pixel Y to VGA adapter
- color_out  out  3  pixel color to VGA adapter
- owner  out  3  index of current grantee; valid only while busy=1
- busy  out  1  a grant is active
- timeout_err  out  1  sticky; set on watchdog revoke, cleared by reset only
- drop_count  out  8  saturating count of plot strobes from non-granted requesters

Behaviour:
- Reset values:
  - grant=0, plot_out=0, x_out=0, y_out=0, color_out=0, owner=0, busy=0, timeout_err=0, drop_count=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has top priority first.
- FSM states: IDLE, OWNED, RELEASE.
- IDLE:
  - If any req is high, pick the first requester scanning upward from pointer+1, wrapping modulo NUM_REQ.
  - Register grant one-hot and owner=index; pointer<=index; busy<=1; go to OWNED.
  - Grant is asserted 1 cycle after req is sampled.
- OWNED:
  - Outputs are registered copies of the owner's slice: plot_out<=plot_in[owner], and likewise x/y/color. Latency from plot_in to plot_out is 1 cycle.
  - When req[owner] is low: clear grant, clear busy, go to RELEASE.
  - Pixel data presented in the same cycle req drops is discarded.
- Watchdog:
  - A hold counter resets on each grant.
  - When MAX_HOLD>0 and the counter reaches MAX_HOLD: force grant to 0, set timeout_err, go to RELEASE. Requester behaviour after this is not the arbiter's concern.
- RELEASE:
  - Exactly one dead cycle with plot_out=0, then IDLE.
  - Guarantees at least one cycle with no grant between owners.
  - A requester that still holds req after revocation is eligible again in IDLE, subject to round robin.
- plot_out is 0 in IDLE and RELEASE; x/y/color hold their last values.
- drop_count:
  - Increments by 1 per cycle in which at least one non-owner plot_in is high. In IDLE and RELEASE every plot_in counts as non-owner.
  - Saturates at 255.
- Simultaneous events:
  - Multiple reqs in IDLE are resolved by round robin.
  - A req rising in the same cycle the owner drops is served only after RELEASE.
- Reset mid-burst: all outputs return to reset values on the next edge; the pointer resets too.

Decomposition:
- Shared package holds:
  - VGA widths: X_W=9, Y_W=8, COLOR_W=3.
  - Requester index constants: REQ_MAP=0, REQ_SPRITE=1, REQ_ANIM=2.
  - FSM state encodings.
- One natural sub-module: rr_pick, a combinational round-robin first-one finder. Inputs: req vector and pointer. Outputs: index and found flag.

Test Plan:
- Single requester: reset, req[0]=1 at cycle 2 → grant=001 at cycle 3. Drive plot_in[0]=1, x=319, y=239, color=7 → next cycle plot_out=1, x_out=319, y_out=239, color_out=7.
- Simultaneous requests: req=111 from IDLE → grants in order 0,1,2, each owner dropping req after 4 cycles. Each handover shows exactly 1 cycle with grant=000 and plot_out=0.
- Fairness: req[0] and req[1] held permanently with bursts ended by toggling req low for 1 cycle → grants alternate 0,1,0,1. Requester 0 must not take two grants in a row.
- Drops: owner=0 while requester 1 pulses plot_in 300 times → drop_count=255 (saturated) and plot_out driven only by requester 0.
- Watchdog: MAX_HOLD=16 with req[2] held forever → grant revoked at cycle 16 of the grant, timeout_err=1. Re-grant occurs after RELEASE, and timeout_err stays 1.
- Reset mid-burst: assert reset while owner=1 with plot active → next edge grant=0, plot_out=0, busy=0. After reset deasserts, requester 0 wins if both are requesting.
